// File: rtl/uart_gpio_bridge.sv
// UART-controlled GPIO bridge: pad 0 is RX, pad 1 is TX, and pads 2..11 are
// host-programmable GPIO. The host uses 'W' to write outputs, 'E' to write enables and 'R' to read inputs.
module uart_gpio_bridge #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] io_in,
    output logic [11:0] io_out,
    output logic [11:0] io_oeb,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    // Handshakes: rx_valid/rx_ferr are single-cycle pulses with no backpressure.
    // tx_start is honoured only while tx_ready is high; one pulse sends one byte.

    logic [11:0] sync1, sync2;
    logic        rx_s;
    logic [9:0]  gpi_s;
    logic        unused_sync;

    // Bit 0 resets high so an idle RX line does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 12'h001;
            sync2 <= 12'h001;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

    assign rx_s        = sync2[0];
    assign gpi_s       = sync2[11:2];
    assign unused_sync = sync2[1];

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_prev;
    logic            rx_valid;
    logic            rx_ferr;
    logic [7:0]      rx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_prev  <= 1'b1;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_prev  <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) rx_valid <= 1'b1;
                        else      rx_ferr  <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte = rx_shift;

    logic            tx_busy;
    logic            tx_ready;
    logic            tx_line;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_idx;
    logic [8:0]      tx_shift;
    logic            tx_start;
    logic [7:0]      tx_data;

    // tx_idx counts the bit being held on the line: 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy  <= 1'b1;
                tx_line  <= 1'b0;
                tx_shift <= {1'b1, tx_data};
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end
        end else if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx_line  <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_idx   <= tx_idx + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx_ready = !tx_busy;

    typedef enum logic [2:0] {P_IDLE, W_HI, W_LO, E_HI, E_LO, R_HI, R_LO, NAK} p_state_t;
    p_state_t    p_state;
    logic [1:0]  hi;
    logic [9:0]  out_reg;
    logic [9:0]  oe_reg;
    logic [9:0]  rd_snap;

    // The !tx_start guard covers the cycle in which the TX has not yet seen the previous pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state  <= P_IDLE;
            hi       <= '0;
            out_reg  <= '0;
            oe_reg   <= '0;
            rd_snap  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            if (rx_ferr) begin
                p_state <= P_IDLE;
            end else begin
                case (p_state)
                    P_IDLE: begin
                        if (rx_valid) begin
                            case (rx_byte)
                                8'h57:   p_state <= W_HI;
                                8'h45:   p_state <= E_HI;
                                8'h52: begin
                                    rd_snap <= gpi_s;
                                    p_state <= R_HI;
                                end
                                default: p_state <= NAK;
                            endcase
                        end
                    end
                    W_HI, E_HI: begin
                        if (rx_valid) begin
                            hi      <= rx_byte[1:0];
                            p_state <= (p_state == W_HI) ? W_LO : E_LO;
                        end
                    end
                    W_LO: begin
                        if (rx_valid) begin
                            out_reg <= {hi, rx_byte};
                            p_state <= P_IDLE;
                        end
                    end
                    E_LO: begin
                        if (rx_valid) begin
                            oe_reg  <= {hi, rx_byte};
                            p_state <= P_IDLE;
                        end
                    end
                    R_HI: begin
                        if (tx_ready && !tx_start) begin
                            tx_start <= 1'b1;
                            tx_data  <= {6'b0, rd_snap[9:8]};
                            p_state  <= R_LO;
                        end
                    end
                    R_LO: begin
                        if (tx_ready && !tx_start) begin
                            tx_start <= 1'b1;
                            tx_data  <= rd_snap[7:0];
                            p_state  <= P_IDLE;
                        end
                    end
                    NAK: begin
                        if (tx_ready && !tx_start) begin
                            tx_start <= 1'b1;
                            tx_data  <= 8'h3F;
                            p_state  <= P_IDLE;
                        end
                    end
                    default: p_state <= P_IDLE;
                endcase
            end
        end
    end

    assign io_out    = {out_reg, tx_line, 1'b0};
    assign io_oeb    = {~oe_reg, 1'b0, 1'b1};
    assign dbg_state = p_state;

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Self-checking bench for uart_gpio_bridge: table-driven W/E writes with update timing,
// plus hand-written readback, NAK, framing-error, glitch and reset sequences.
module tb_uart_gpio_bridge;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic [11:0] io_in;
    logic [11:0] io_out;
    logic [11:0] io_oeb;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    uart_gpio_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one frame on the RX pad; every bit is held for CPB clocks.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            io_in[0] = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    // Same frame, but during the stop bit record the first clock at which the pads
    // show the expected values (counted from the stop bit's first rising edge).
    task automatic send_byte_timed(input logic [7:0] b, input logic [11:0] e_out,
                                   input logic [11:0] e_oeb, output int first_k);
        logic [8:0] frame;
        frame   = {b, 1'b0};
        first_k = -1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            io_in[0] = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        io_in[0] = 1'b1;
        for (int k = 0; k < CPB; k++) begin
            @(posedge clk);
            #1;
            if (first_k < 0 && io_out == e_out && io_oeb == e_oeb) first_k = k;
        end
    endtask

    task automatic wait_tx_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check({name, "_timeout"}, exp_q.size(), 0);
        repeat (2 * CPB) @(posedge clk);
    endtask

    // TX monitor: decode frames on io_out[1], check 16-cycle bit widths, pop scoreboard.
    initial begin : tx_monitor
        logic       prev;
        logic       first;
        logic       ok;
        logic       aborted;
        logic [9:0] bits;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && prev && !io_out[1]) begin
                ok      = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                first   = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (b != 0 || k != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (rst) aborted = 1'b1;
                        if (k == 0) first = io_out[1];
                        else if (io_out[1] !== first) ok = 1'b0;
                    end
                    bits[b] = first;
                end
                if (!aborted) begin
                    check("tx_frame_shape", {ok, bits[9], bits[0]}, 3'b110);
                    if (exp_q.size() == 0) check("tx_unexpected_byte", bits[8:1], 9'h100);
                    else check("tx_byte", bits[8:1], exp_q.pop_front());
                end
            end
            prev = io_out[1];
        end
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [11:0] exp_out;
        logic [11:0] exp_oeb;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int k;
        int n;
        vecs[0] = '{8'h45, 8'h03, 8'hFF, 12'h002, 12'h001};
        vecs[1] = '{8'h57, 8'h02, 8'hA5, 12'hA96, 12'h001};
        vecs[2] = '{8'h57, 8'hFC, 8'h3C, 12'h0F2, 12'h001};
        vecs[3] = '{8'h57, 8'hFF, 8'h00, 12'hC02, 12'h001};
        vecs[4] = '{8'h45, 8'h01, 8'hF0, 12'hC02, 12'h83D};

        rst   = 1'b1;
        io_in = 12'h001;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_io_out", io_out, 12'h002);
        check("reset_io_oeb", io_oeb, 12'hFFD);
        check("reset_state", dbg_state, 3'd0);

        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].b0, 1'b1);
            send_byte(vecs[v].b1, 1'b1);
            send_byte_timed(vecs[v].b2, vecs[v].exp_out, vecs[v].exp_oeb, k);
            check($sformatf("vec%0d_update_cycle", v), k, 11);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_io_out", v), io_out, vecs[v].exp_out);
            check($sformatf("vec%0d_io_oeb", v), io_oeb, vecs[v].exp_oeb);
        end

        // Readback, with a 'W' arriving during the response that must be ignored.
        @(negedge clk);
        io_in[11:2] = 10'h15A;
        repeat (8) @(negedge clk);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h5A);
        send_byte(8'h52, 1'b1);
        send_byte(8'h57, 1'b1);
        wait_tx_drain("readback");
        check("readback_io_out", io_out, 12'hC02);
        check("readback_state", dbg_state, 3'd0);

        // Unknown command gets a NAK, then the parser is usable again.
        exp_q.push_back(8'h3F);
        send_byte(8'h13, 1'b1);
        wait_tx_drain("nak");
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("nak_then_write_io_out", io_out, 12'h006);
        check("nak_then_write_io_oeb", io_oeb, 12'h83D);

        // Framing error drops the 'W'; the following 'E' parses from IDLE.
        send_byte(8'h57, 1'b0);
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h45, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0F, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("ferr_io_oeb", io_oeb, 12'hFC1);
        check("ferr_io_out", io_out, 12'h006);
        check("ferr_state", dbg_state, 3'd0);

        // Short low glitch on RX is rejected; the next frame is received intact.
        @(negedge clk);
        io_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        io_in[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_state", dbg_state, 3'd0);
        check("glitch_io_out", io_out, 12'h006);
        send_byte(8'h57, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("after_glitch_io_out", io_out, 12'h48E);
        check("after_glitch_io_oeb", io_oeb, 12'hFC1);

        // Reset in the middle of a NAK transmission.
        send_byte(8'h13, 1'b1);
        n = 0;
        while (io_out[1] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("tx_started_before_reset", io_out[1], 1'b0);
        repeat (3 * CPB + 3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_io_out", io_out, 12'h002);
        check("async_reset_io_oeb", io_oeb, 12'hFFD);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("post_reset_io_out", io_out, 12'h002);
        check("post_reset_state", dbg_state, 3'd0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("post_reset_write_io_out", io_out, 12'hFFE);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_gpio_bridge.md
# uart_gpio_bridge

User-design block instantiated inside `top`, directly downstream of the 12 bidirectional IO pad cells: it consumes `io_in[11:0]` and produces `io_out[11:0]` / `io_oeb[11:0]`. Pad 0 is a UART RX line and pad 1 is a UART TX line. A small byte-command protocol on these two pads sets output values and output enables for pads 2..11 and reads their input levels back. This provides host-driven bring-up of the fabric IO path without reconfiguring the fabric.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be even and ≥ 4.
- `clk` in 1: single clock, from `Global_Clock`.
- `rst` in 1: asynchronous, active-high reset.
- `io_in` in 12: pad inputs. Bit 0 is RX. Bits 11:2 are GPIO inputs. Bit 1 is ignored.
- `io_out` out 12: pad outputs. Bit 1 is TX. Bits 11:2 come from `out_reg`. Bit 0 is 0.
- `io_oeb` out 12: output-enable-bar, where 1 means input. Bit 0 is always 1. Bit 1 is always 0. Bits 11:2 are `~oe_reg`.

## Operation
- **Synchronisers:** all 12 `io_in` bits pass through 2-flop synchronisers. `rx_s` = sync(io_in[0]). `gpi_s[9:0]` = sync(io_in[11:2]).
- **RX:**
  - Idle until a falling edge on `rx_s`.
  - Re-sample at CLKS_PER_BIT/2. If `rx_s` is high there, return to idle (glitch rejection).
  - Then sample 8 data bits LSB-first, then the stop bit, each exactly CLKS_PER_BIT after the previous sample.
  - Stop=1: pulse `rx_valid` for 1 cycle with `rx_byte`.
  - Stop=0 (framing error): no `rx_valid`; pulse `rx_ferr`, which forces the parser to IDLE.
- **TX:**
  - Format is 8N1, LSB first, idle high.
  - `tx_ready` is high when idle. A `tx_start` while ready latches the byte.
- **Parser FSM states:** IDLE, W_HI, W_LO, E_HI, E_LO, R_HI, R_LO, NAK. Transitions on `rx_valid` in IDLE:
  - 0x57 'W' → W_HI. The next byte's bits [1:0] become hi. The next byte after that becomes lo. In W_LO, when that byte arrives: `out_reg[9:0]` ← {hi[1:0], lo}, then → IDLE. Hi bits [7:2] are ignored.
  - 0x45 'E' → E_HI → E_LO. Identical to W, but writes `oe_reg[9:0]`.
  - 0x52 'R' → snapshot `gpi_s` into `rd_snap` in the same cycle, then → R_HI.
    - R_HI: when `tx_ready`, send {6'b0, rd_snap[9:8]}, → R_LO.
    - R_LO: when `tx_ready`, send rd_snap[7:0], → IDLE.
  - Any other byte → NAK. NAK: when `tx_ready`, send 0x3F, → IDLE.
- **Discarded bytes:** bytes received while in R_HI, R_LO or NAK are discarded silently.
- **Framing error:** `rx_ferr` in any state → IDLE. A partial W/E write is abandoned and its register is unchanged. A transmission already in flight completes.
- **Reset values:** `out_reg`=0, `oe_reg`=0, FSM=IDLE, TX idle. Therefore `io_out`=12'h002 and `io_oeb`=12'hFFD.
- **Reset mid-frame:** TX line returns to 1 immediately (asynchronously). The RX frame and parser state are lost.

## Timing
- RX latency: `rx_valid` is asserted in the cycle of the mid-stop-bit sample. Counting from the pad falling edge, that is ≈ 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- Register write: `out_reg`/`oe_reg`, and therefore `io_out`/`io_oeb`, update on the clock edge ending the `rx_valid` cycle of the final data byte. The pads change 1 cycle after `rx_valid`.
- R snapshot: taken at the `rx_valid` cycle of 0x52. It reflects the pad levels from 2 cycles earlier.
- TX frame timing:
  - The start bit appears on `io_out[1]` in the cycle after `tx_start`.
  - Each bit is held exactly CLKS_PER_BIT cycles. The frame is 10·CLKS_PER_BIT cycles.
  - `tx_ready` rises in the cycle after the stop bit ends.
- Bytes sent back-to-back by the host with one stop bit are all accepted; the RX path has no dead time beyond the stop sample.

## Test plan
- **Reset:** assert `rst` mid-operation → `io_out`=12'h002 and `io_oeb`=12'hFFD immediately; TX line is high.
- **Writes** (CLKS_PER_BIT=16): send 0x45,0x03,0xFF, then 0x57,0x02,0xA5 → `io_oeb`=12'h001 and `io_out`=12'hA96. Each takes effect 1 cycle after the last byte's `rx_valid`.
- **Readback:** drive io_in[11:2]=10'h15A, send 0x52 → TX emits 0x01 then 0x5A, each with bit width exactly 16 cycles. A 0x57 sent during the response is discarded and `io_out` is unchanged.
- **NAK:** send 0x13 → TX emits 0x3F. A subsequent 0x57,0x00,0x01 sets `io_out`=12'h006.
- **Framing error:** send 0x57 with stop=0, then 0x45,0x00,0x0F → the first byte is dropped and the parser starts from IDLE. Result: `io_oeb`=12'hFC1, `io_out` unchanged.
- **Glitch rejection:** hold RX low for 3 cycles → no `rx_valid`, no state change. The next valid frame is received correctly.
